// File: rtl/m5_mig_arbiter_pkg.sv
// Shared types for the migration-address arbiter: source tag and queued request.
package m5_pkg;

  localparam int M5_ADDR_SIZE = 28;

  typedef enum logic {
    M5_SRC_CACHE = 1'b0,
    M5_SRC_PAGE  = 1'b1
  } m5_src_e;

  typedef struct packed {
    m5_src_e                  src;
    logic [M5_ADDR_SIZE-1:0]  addr;
  } m5_mig_req_t;

endpackage

// File: rtl/m5_mig_arbiter_if.sv
// Source-side and engine-side handshake bundle of the migration arbiter.
interface m5_mig_arbiter_if
  import m5_pkg::*;
#(
  parameter int ADDR_SIZE = M5_ADDR_SIZE
) ();

  logic                 cache_mig_addr_en;
  logic [ADDR_SIZE-1:0] cache_mig_addr;
  logic                 cache_mig_ready;
  logic                 page_mig_addr_en;
  logic [ADDR_SIZE-1:0] page_mig_addr;
  logic                 page_mig_ready;
  logic                 mig_req_valid;
  logic                 mig_req_src;
  logic [ADDR_SIZE-1:0] mig_req_addr;
  logic                 mig_req_ready;

  modport slave (
    input  cache_mig_addr_en, cache_mig_addr, page_mig_addr_en, page_mig_addr, mig_req_ready,
    output cache_mig_ready, page_mig_ready, mig_req_valid, mig_req_src, mig_req_addr
  );

  modport master (
    output cache_mig_addr_en, cache_mig_addr, page_mig_addr_en, page_mig_addr, mig_req_ready,
    input  cache_mig_ready, page_mig_ready, mig_req_valid, mig_req_src, mig_req_addr
  );

endinterface

// File: rtl/m5_mig_arbiter_sync_fifo.sv
// First-word-fall-through queue; head is visible on dout whenever not empty.
module m5_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // full/empty come from the registered level, so a pop never frees space in the same cycle
  always_comb begin
    full    = (level == (AW+1)'(DEPTH));
    empty   = (level == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_ptr];
  end

  // storage array; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/m5_mig_arbiter.sv
// Round-robin merge of cache-line and page migration streams with per-source
// back-to-back duplicate suppression and saturating accept/drop statistics.
module m5_mig_arbiter
  import m5_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        arb_en,
  input  logic                        clear_stats,
  m5_mig_arbiter_if.slave             mig,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_WIDTH-1:0]        cache_acc_cnt,
  output logic [CNT_WIDTH-1:0]        page_acc_cnt,
  output logic [CNT_WIDTH-1:0]        cache_drop_cnt,
  output logic [CNT_WIDTH-1:0]        page_drop_cnt
);

  localparam int ADDR_SIZE = M5_ADDR_SIZE;

  logic                 run_q;
  m5_src_e              rr_last;
  logic [ADDR_SIZE-1:0] last_addr [2];
  logic                 last_vld  [2];
  logic [CNT_WIDTH-1:0] acc_cnt   [2];
  logic [CNT_WIDTH-1:0] drop_cnt  [2];

  logic                 full;
  logic                 empty;
  logic                 can_accept;
  logic                 grant_cache;
  logic                 grant_page;
  logic                 xfer;
  logic                 dup;
  logic                 push;
  m5_src_e              xfer_src;
  logic [ADDR_SIZE-1:0] xfer_addr;
  m5_mig_req_t          push_req;
  m5_mig_req_t          head_req;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // grant: single requester wins, otherwise the source that did not transfer last
  always_comb begin
    can_accept  = run_q && arb_en && !full;
    grant_cache = can_accept && mig.cache_mig_addr_en &&
                  (!mig.page_mig_addr_en || rr_last == M5_SRC_PAGE);
    grant_page  = can_accept && mig.page_mig_addr_en &&
                  (!mig.cache_mig_addr_en || rr_last == M5_SRC_CACHE);
    xfer        = grant_cache || grant_page;
    xfer_src    = grant_page ? M5_SRC_PAGE : M5_SRC_CACHE;
    xfer_addr   = grant_page ? mig.page_mig_addr : mig.cache_mig_addr;
    dup         = last_vld[xfer_src] && (xfer_addr == last_addr[xfer_src]);
    push        = xfer && !dup;
    push_req.src  = xfer_src;
    push_req.addr = xfer_addr;
  end

  // ready is held low until the first clock after reset release; rr_last moves on every transfer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q   <= 1'b0;
      rr_last <= M5_SRC_PAGE;
    end else begin
      run_q <= 1'b1;
      if (xfer) rr_last <= xfer_src;
    end
  end

  // dedup history and statistics; clear overrides a same-cycle increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < 2; s++) begin
        last_addr[s] <= '0;
        last_vld[s]  <= 1'b0;
        acc_cnt[s]   <= '0;
        drop_cnt[s]  <= '0;
      end
    end else if (clear_stats) begin
      for (int s = 0; s < 2; s++) begin
        last_vld[s] <= 1'b0;
        acc_cnt[s]  <= '0;
        drop_cnt[s] <= '0;
      end
    end else if (xfer) begin
      if (dup) begin
        drop_cnt[xfer_src] <= sat_inc(drop_cnt[xfer_src]);
      end else begin
        acc_cnt[xfer_src]   <= sat_inc(acc_cnt[xfer_src]);
        last_addr[xfer_src] <= xfer_addr;
        last_vld[xfer_src]  <= 1'b1;
      end
    end
  end

  m5_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(m5_mig_req_t))
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (push_req),
    .pop   (mig.mig_req_ready),
    .dout  (head_req),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  // handshake and statistics outputs
  always_comb begin
    mig.cache_mig_ready = grant_cache;
    mig.page_mig_ready  = grant_page;
    mig.mig_req_valid   = !empty;
    mig.mig_req_src     = head_req.src;
    mig.mig_req_addr    = head_req.addr;
    cache_acc_cnt       = acc_cnt[0];
    page_acc_cnt        = acc_cnt[1];
    cache_drop_cnt      = drop_cnt[0];
    page_drop_cnt       = drop_cnt[1];
  end

endmodule

// File: tb/tb_m5_mig_arbiter.sv
// Directed bench for m5_mig_arbiter: reset, round robin, dedup, full queue,
// clear_stats and arb_en drain with an asynchronous reset mid-drain.
module tb_m5_mig_arbiter;

  logic        clk;
  logic        rstn;
  logic        arb_en;
  logic        clear_stats;
  logic [3:0]  fifo_level;
  logic [31:0] cache_acc_cnt, page_acc_cnt, cache_drop_cnt, page_drop_cnt;
  int          n_cmp;
  int          n_err;

  m5_mig_arbiter_if mif ();

  m5_mig_arbiter dut (
    .clk            (clk),
    .rstn           (rstn),
    .arb_en         (arb_en),
    .clear_stats    (clear_stats),
    .mig            (mif),
    .fifo_level     (fifo_level),
    .cache_acc_cnt  (cache_acc_cnt),
    .page_acc_cnt   (page_acc_cnt),
    .cache_drop_cnt (cache_drop_cnt),
    .page_drop_cnt  (page_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rstn = 1'b0; arb_en = 1'b1; clear_stats = 1'b0;
    mif.cache_mig_addr_en = 1'b1; mif.cache_mig_addr = 28'h0;
    mif.page_mig_addr_en  = 1'b1; mif.page_mig_addr  = 28'h0;
    mif.mig_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (mif.cache_mig_ready !== 1'b0) begin n_err++; $display("FAIL rst_cache_ready: got %0h want 0", mif.cache_mig_ready); end
    n_cmp++; if (mif.page_mig_ready !== 1'b0) begin n_err++; $display("FAIL rst_page_ready: got %0h want 0", mif.page_mig_ready); end
    n_cmp++; if (mif.mig_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h want 0", mif.mig_req_valid); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    n_cmp++; if (cache_acc_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cache_acc: got %0d want 0", cache_acc_cnt); end
    n_cmp++; if (page_acc_cnt !== 32'd0) begin n_err++; $display("FAIL rst_page_acc: got %0d want 0", page_acc_cnt); end
    n_cmp++; if (cache_drop_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cache_drop: got %0d want 0", cache_drop_cnt); end
    n_cmp++; if (page_drop_cnt !== 32'd0) begin n_err++; $display("FAIL rst_page_drop: got %0d want 0", page_drop_cnt); end
    mif.cache_mig_addr_en = 1'b0;
    mif.page_mig_addr_en  = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic        exp_src;
    logic [27:0] exp_addr, ca, pa;
    int          ci, pi;
    ci = 0; pi = 0; exp_src = 1'b0; exp_addr = 28'h0;
    mif.mig_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ca = 28'h10 + 28'(ci);
      pa = 28'h20 + 28'(pi);
      mif.cache_mig_addr = ca; mif.cache_mig_addr_en = 1'b1;
      mif.page_mig_addr  = pa; mif.page_mig_addr_en  = 1'b1;
      #1;
      n_cmp++; if (mif.cache_mig_ready !== (k % 2 == 0)) begin n_err++; $display("FAIL rr_cache_ready[%0d]: got %0h want %0h", k, mif.cache_mig_ready, (k % 2 == 0)); end
      n_cmp++; if (mif.page_mig_ready !== (k % 2 == 1)) begin n_err++; $display("FAIL rr_page_ready[%0d]: got %0h want %0h", k, mif.page_mig_ready, (k % 2 == 1)); end
      n_cmp++; if (cache_acc_cnt !== 32'((k + 1) / 2)) begin n_err++; $display("FAIL rr_cache_acc[%0d]: got %0d want %0d", k, cache_acc_cnt, (k + 1) / 2); end
      n_cmp++; if (page_acc_cnt !== 32'(k / 2)) begin n_err++; $display("FAIL rr_page_acc[%0d]: got %0d want %0d", k, page_acc_cnt, k / 2); end
      if (k > 0) begin
        n_cmp++; if (mif.mig_req_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %0h want 1", k, mif.mig_req_valid); end
        n_cmp++; if (mif.mig_req_src !== exp_src) begin n_err++; $display("FAIL rr_src[%0d]: got %0h want %0h", k, mif.mig_req_src, exp_src); end
        n_cmp++; if (mif.mig_req_addr !== exp_addr) begin n_err++; $display("FAIL rr_addr[%0d]: got %0h want %0h", k, mif.mig_req_addr, exp_addr); end
      end
      if (k % 2 == 0) begin exp_src = 1'b0; exp_addr = ca; ci++; end
      else            begin exp_src = 1'b1; exp_addr = pa; pi++; end
      @(posedge clk); #1;
    end
    mif.cache_mig_addr_en = 1'b0;
    mif.page_mig_addr_en  = 1'b0;
    #1;
    n_cmp++; if (mif.mig_req_addr !== 28'h22 || mif.mig_req_src !== 1'b1) begin n_err++; $display("FAIL rr_last_head: got %0h/%0h want 1/22", mif.mig_req_src, mif.mig_req_addr); end
    n_cmp++; if (fifo_level !== 4'd1) begin n_err++; $display("FAIL rr_level: got %0d want 1", fifo_level); end
    @(posedge clk); #1;
    n_cmp++; if (mif.mig_req_valid !== 1'b0) begin n_err++; $display("FAIL rr_drained: got %0h want 0", mif.mig_req_valid); end
    n_cmp++; if (cache_acc_cnt !== 32'd3 || page_acc_cnt !== 32'd3) begin n_err++; $display("FAIL rr_final_acc: got %0d/%0d want 3/3", cache_acc_cnt, page_acc_cnt); end
  endtask

  task automatic test_dedup();
    logic [27:0] seq [3];
    seq[0] = 28'h100; seq[1] = 28'h100; seq[2] = 28'h101;
    mif.mig_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mif.cache_mig_addr_en = 1'b1; mif.cache_mig_addr = seq[i];
      #1;
      n_cmp++; if (mif.cache_mig_ready !== 1'b1) begin n_err++; $display("FAIL dd_ready[%0d]: got %0h want 1", i, mif.cache_mig_ready); end
      @(posedge clk); #1;
    end
    mif.cache_mig_addr_en = 1'b0;
    #1;
    n_cmp++; if (fifo_level !== 4'd2) begin n_err++; $display("FAIL dd_level: got %0d want 2", fifo_level); end
    n_cmp++; if (mif.mig_req_addr !== 28'h100) begin n_err++; $display("FAIL dd_head0: got %0h want 100", mif.mig_req_addr); end
    n_cmp++; if (cache_drop_cnt !== 32'd1) begin n_err++; $display("FAIL dd_drop: got %0d want 1", cache_drop_cnt); end
    n_cmp++; if (cache_acc_cnt !== 32'd5) begin n_err++; $display("FAIL dd_acc: got %0d want 5", cache_acc_cnt); end
    mif.mig_req_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (mif.mig_req_addr !== 28'h101 || fifo_level !== 4'd1) begin n_err++; $display("FAIL dd_head1: got %0h lvl %0d want 101 lvl 1", mif.mig_req_addr, fifo_level); end
    @(posedge clk); #1;
    mif.mig_req_ready = 1'b0;
    n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL dd_empty: got %0d want 0", fifo_level); end
  endtask

  task automatic test_full();
    mif.mig_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mif.page_mig_addr_en = 1'b1; mif.page_mig_addr = 28'h200 + 28'(i);
      #1;
      n_cmp++; if (mif.page_mig_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready[%0d]: got %0h want 1", i, mif.page_mig_ready); end
      @(posedge clk); #1;
    end
    mif.page_mig_addr = 28'h208;
    #1;
    n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL fl_level_full: got %0d want 8", fifo_level); end
    n_cmp++; if (mif.page_mig_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready_full: got %0h want 0", mif.page_mig_ready); end
    mif.mig_req_ready = 1'b1;
    #1;
    n_cmp++; if (mif.page_mig_ready !== 1'b0) begin n_err++; $display("FAIL fl_no_popthru: got %0h want 0", mif.page_mig_ready); end
    @(posedge clk); #1;
    mif.mig_req_ready = 1'b0;
    #1;
    n_cmp++; if (fifo_level !== 4'd7 || mif.page_mig_ready !== 1'b1) begin n_err++; $display("FAIL fl_after_pop: got lvl %0d rdy %0h want 7/1", fifo_level, mif.page_mig_ready); end
    @(posedge clk); #1;
    mif.page_mig_addr_en = 1'b0;
    n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL fl_refill: got %0d want 8", fifo_level); end
    mif.mig_req_ready = 1'b1;
    #1;
    n_cmp++; if (mif.mig_req_addr !== 28'h201) begin n_err++; $display("FAIL fl_head: got %0h want 201", mif.mig_req_addr); end
    repeat (8) @(posedge clk);
    #1;
    mif.mig_req_ready = 1'b0;
    n_cmp++; if (fifo_level !== 4'd0 || mif.mig_req_valid !== 1'b0) begin n_err++; $display("FAIL fl_drain: got lvl %0d vld %0h want 0/0", fifo_level, mif.mig_req_valid); end
    n_cmp++; if (page_acc_cnt !== 32'd12) begin n_err++; $display("FAIL fl_page_acc: got %0d want 12", page_acc_cnt); end
  endtask

  task automatic test_clear_stats();
    mif.cache_mig_addr_en = 1'b1; mif.cache_mig_addr = 28'h300; clear_stats = 1'b1;
    #1;
    n_cmp++; if (mif.cache_mig_ready !== 1'b1) begin n_err++; $display("FAIL cs_ready: got %0h want 1", mif.cache_mig_ready); end
    @(posedge clk); #1;
    clear_stats = 1'b0; mif.cache_mig_addr_en = 1'b0;
    #1;
    n_cmp++; if (cache_acc_cnt !== 32'd0 || page_acc_cnt !== 32'd0) begin n_err++; $display("FAIL cs_acc: got %0d/%0d want 0/0", cache_acc_cnt, page_acc_cnt); end
    n_cmp++; if (cache_drop_cnt !== 32'd0 || page_drop_cnt !== 32'd0) begin n_err++; $display("FAIL cs_drop: got %0d/%0d want 0/0", cache_drop_cnt, page_drop_cnt); end
    n_cmp++; if (fifo_level !== 4'd1) begin n_err++; $display("FAIL cs_level1: got %0d want 1", fifo_level); end
    mif.cache_mig_addr_en = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (fifo_level !== 4'd2 || cache_acc_cnt !== 32'd1 || cache_drop_cnt !== 32'd0) begin n_err++; $display("FAIL cs_repeat_enq: got lvl %0d acc %0d drop %0d want 2/1/0", fifo_level, cache_acc_cnt, cache_drop_cnt); end
    @(posedge clk); #1;
    mif.cache_mig_addr_en = 1'b0;
    n_cmp++; if (fifo_level !== 4'd2 || cache_drop_cnt !== 32'd1) begin n_err++; $display("FAIL cs_repeat_drop: got lvl %0d drop %0d want 2/1", fifo_level, cache_drop_cnt); end
    mif.page_mig_addr_en = 1'b1; mif.page_mig_addr = 28'h400;
    @(posedge clk); #1;
    mif.page_mig_addr_en = 1'b0;
    n_cmp++; if (fifo_level !== 4'd3 || page_acc_cnt !== 32'd1) begin n_err++; $display("FAIL cs_page: got lvl %0d acc %0d want 3/1", fifo_level, page_acc_cnt); end
  endtask

  task automatic test_arb_en_drain();
    arb_en = 1'b0;
    mif.cache_mig_addr_en = 1'b1; mif.cache_mig_addr = 28'h500;
    mif.page_mig_addr_en  = 1'b1; mif.page_mig_addr  = 28'h501;
    #1;
    n_cmp++; if (mif.cache_mig_ready !== 1'b0 || mif.page_mig_ready !== 1'b0) begin n_err++; $display("FAIL ae_readys: got %0h/%0h want 0/0", mif.cache_mig_ready, mif.page_mig_ready); end
    n_cmp++; if (mif.mig_req_src !== 1'b0 || mif.mig_req_addr !== 28'h300) begin n_err++; $display("FAIL ae_head0: got %0h/%0h want 0/300", mif.mig_req_src, mif.mig_req_addr); end
    mif.mig_req_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (mif.mig_req_addr !== 28'h300 || fifo_level !== 4'd2) begin n_err++; $display("FAIL ae_head1: got %0h lvl %0d want 300 lvl 2", mif.mig_req_addr, fifo_level); end
    @(posedge clk); #1;
    n_cmp++; if (mif.mig_req_src !== 1'b1 || mif.mig_req_addr !== 28'h400 || fifo_level !== 4'd1) begin n_err++; $display("FAIL ae_head2: got %0h/%0h lvl %0d want 1/400 lvl 1", mif.mig_req_src, mif.mig_req_addr, fifo_level); end
    n_cmp++; if (mif.cache_mig_ready !== 1'b0 || mif.page_mig_ready !== 1'b0) begin n_err++; $display("FAIL ae_readys_drain: got %0h/%0h want 0/0", mif.cache_mig_ready, mif.page_mig_ready); end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (mif.mig_req_valid !== 1'b0 || fifo_level !== 4'd0) begin n_err++; $display("FAIL ae_async_rst: got vld %0h lvl %0d want 0/0", mif.mig_req_valid, fifo_level); end
    n_cmp++; if (cache_acc_cnt !== 32'd0 || page_acc_cnt !== 32'd0 || cache_drop_cnt !== 32'd0) begin n_err++; $display("FAIL ae_rst_cnt: got %0d/%0d/%0d want 0/0/0", cache_acc_cnt, page_acc_cnt, cache_drop_cnt); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_round_robin();
    test_dedup();
    test_full();
    test_clear_stats();
    test_arb_en_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
